// File: rtl/axi_r_stream_tap_pkg.sv
// Shared types and constants for the AXI R-channel stream tap.
package axi_r_stream_tap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp >= SLVERR);
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with a combinational head view; DEPTH must be a power of two.
module stream_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == {CW{1'b0}});
   assign head_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers (wrapping naturally at DEPTH) and occupancy.
   always_comb begin
      do_push_s = push & ~full;
      do_pop_s  = pop & ~empty;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/axi_r_stream_tap.sv
// Passes an AXI R channel through unchanged while copying each burst, framed by a
// header word, into a tap stream; error beats are replaced by a status word.
module axi_r_stream_tap
   import axi_r_stream_tap_pkg::*;
#(
   parameter int                           DATA_WIDTH        = 128,
   parameter int                           ID_WIDTH          = 32,
   parameter int                           USER_WIDTH        = 64,
   parameter int                           STREAM_TYPE_WIDTH = 3,
   parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b010,
   parameter int                           FIFO_DEPTH        = 4,
   parameter int                           MAX_BURST         = 256
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ID_WIDTH-1:0]   AXIM_rid,
   input  logic [DATA_WIDTH-1:0] AXIM_rdata,
   input  logic [1:0]            AXIM_rresp,
   input  logic                  AXIM_rlast,
   input  logic [USER_WIDTH-1:0] AXIM_ruser,
   input  logic                  AXIM_rvalid,
   output logic                  AXIM_rready,
   output logic [ID_WIDTH-1:0]   AXIS_rid,
   output logic [DATA_WIDTH-1:0] AXIS_rdata,
   output logic [1:0]            AXIS_rresp,
   output logic                  AXIS_rlast,
   output logic [USER_WIDTH-1:0] AXIS_ruser,
   output logic                  AXIS_rvalid,
   input  logic                  AXIS_rready,
   output logic                  tap_valid,
   input  logic                  tap_ready,
   output logic [DATA_WIDTH-1:0] tap_data,
   output logic                  tap_last,
   output logic                  in_progress,
   output logic                  err_resp,
   output logic                  err_overflow
);

   localparam int                BW       = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0]     LAST_IDX = BW'(MAX_BURST - 1);

   state_e                state_q, state_d;
   logic [BW-1:0]         beat_idx_q, beat_idx_d;
   logic                  err_resp_q, err_resp_d;
   logic                  err_ovf_q, err_ovf_d;
   logic                  fifo_full_s, fifo_empty_s;
   logic                  push_s;
   logic [DATA_WIDTH:0]   push_word_s;
   logic [DATA_WIDTH:0]   head_word_s;
   logic [DATA_WIDTH-1:0] hdr_word_s;
   logic [DATA_WIDTH-1:0] err_word_s;
   logic                  axim_rready_s;
   logic                  axis_rvalid_s;

   assign AXIS_rid     = AXIM_rid;
   assign AXIS_rdata   = AXIM_rdata;
   assign AXIS_rresp   = AXIM_rresp;
   assign AXIS_rlast   = AXIM_rlast;
   assign AXIS_ruser   = AXIM_ruser;
   assign AXIS_rvalid  = axis_rvalid_s;
   assign AXIM_rready  = axim_rready_s;
   assign tap_valid    = ~fifo_empty_s;
   assign tap_data     = head_word_s[DATA_WIDTH-1:0];
   assign tap_last     = head_word_s[DATA_WIDTH];
   assign in_progress  = (state_q != ST_IDLE);
   assign err_resp     = err_resp_q;
   assign err_overflow = err_ovf_q;

   // Header and error-status words: tag in the MSBs, payload in the LSBs.
   always_comb begin
      hdr_word_s                                          = '0;
      hdr_word_s[ID_WIDTH-1:0]                            = AXIM_rid;
      hdr_word_s[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH]       = STREAM_TYPE;
      err_word_s                                          = '0;
      err_word_s[9:0]                                     = {8'(beat_idx_q), AXIM_rresp};
      err_word_s[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH]       = STREAM_TYPE;
   end

   // Burst framing FSM: R handshakes only pass in DATA, and only while the tap has room.
   always_comb begin
      state_d       = state_q;
      beat_idx_d    = beat_idx_q;
      err_resp_d    = err_resp_q;
      err_ovf_d     = err_ovf_q;
      push_s        = 1'b0;
      push_word_s   = '0;
      axim_rready_s = 1'b0;
      axis_rvalid_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (AXIM_rvalid) begin
               state_d = ST_HDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (!fifo_full_s) begin
               push_s      = 1'b1;
               push_word_s = {1'b0, hdr_word_s};
               beat_idx_d  = {BW{1'b0}};
               state_d     = ST_DATA;
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_DATA: begin
            axis_rvalid_s = AXIM_rvalid & ~fifo_full_s;
            axim_rready_s = AXIS_rready & ~fifo_full_s;
            if (AXIM_rvalid && axim_rready_s) begin
               push_s     = 1'b1;
               beat_idx_d = beat_idx_q + BW'(1);
               if (resp_is_err(AXIM_rresp)) begin
                  push_word_s = {AXIM_rlast, err_word_s};
                  err_resp_d  = 1'b1;
               end else begin
                  push_word_s = {AXIM_rlast, AXIM_rdata};
               end
               if (AXIM_rlast) begin
                  state_d = ST_IDLE;
               end else if (beat_idx_q == LAST_IDX) begin
                  // Runaway burst: close the frame ourselves and flag it.
                  push_word_s[DATA_WIDTH] = 1'b1;
                  err_ovf_d               = 1'b1;
                  state_d                 = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and sticky error registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         beat_idx_q <= {BW{1'b0}};
         err_resp_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_idx_q <= beat_idx_d;
         err_resp_q <= err_resp_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   stream_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push_s),
      .push_data (push_word_s),
      .pop       (tap_valid & tap_ready),
      .head_data (head_word_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

endmodule

// File: doc/axi_r_stream_tap.md
AXI_R_STREAM_TAP -- requirements
Module: axi_r_stream_tap

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, R data and tap word width.
REQ-002 SHALL have parameter ID_WIDTH, default 32; USER_WIDTH, default 64.
REQ-003 SHALL have parameter STREAM_TYPE, default 3'b010, and STREAM_TYPE_WIDTH, default 3, the tag placed in tap word MSBs.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of two >= 2, the tap buffer depth.
REQ-005 SHALL have parameter MAX_BURST, default 256, the maximum legal beats per burst.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 resetn  in  1  reset, asynchronous assert, active-low.
REQ-008 AXIM_rid/rdata/rresp/rlast/ruser/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH/1  upstream R channel; AXIM_rready  out  1.
REQ-009 AXIS_rid/rdata/rresp/rlast/ruser/rvalid  out  same widths  downstream R channel; AXIS_rready  in  1.
REQ-010 tap_valid  out  1; tap_ready  in  1; tap_data  out  DATA_WIDTH; tap_last  out  1: tap stream.
REQ-011 in_progress  out  1  high while a burst is open (state != IDLE).
REQ-012 err_resp  out  1; err_overflow  out  1: sticky error flags.

Function
REQ-013 AXIS_rid/rdata/rresp/rlast/ruser SHALL equal the AXIM_r* inputs combinationally.
REQ-014 FSM states: IDLE, HDR, DATA; reset state IDLE.
REQ-015 IDLE -> HDR when AXIM_rvalid=1; no R handshake passes in IDLE (AXIS_rvalid=AXIM_rready=0).
REQ-016 HDR: when the FIFO is not full, push header word {STREAM_TYPE, zeros, AXIM_rid} and go to DATA; no R handshake in HDR.
REQ-017 DATA: AXIS_rvalid = AXIM_rvalid & ~fifo_full; AXIM_rready = AXIS_rready & ~fifo_full.
REQ-018 On each DATA handshake (AXIM_rvalid & AXIM_rready) SHALL push one word: AXIM_rdata if rresp < 2'b10, else {STREAM_TYPE, zeros, beat_idx[7:0], AXIM_rresp}.
REQ-019 Pushed word SHALL carry last = AXIM_rlast; a handshake with rlast=1 returns the FSM to IDLE next cycle.
REQ-020 beat_idx, width $clog2(MAX_BURST)+1, SHALL clear on HDR exit and increment per DATA handshake.
REQ-021 If the MAX_BURST-th beat is handshaken without rlast, SHALL set err_overflow, push that word with last=1 and return to IDLE, without gating further R traffic until the next rvalid-driven HDR.
REQ-022 err_resp SHALL set on any handshake with rresp >= 2'b10; both flags clear only on reset.
REQ-023 FIFO: push only when not full, pop when tap_valid & tap_ready; simultaneous push and pop at full SHALL NOT occur (push is gated by registered full); at empty, pop is impossible (tap_valid=0).
REQ-024 tap_valid = ~fifo_empty; tap_data/tap_last SHALL be the FIFO head, stable while tap_valid & ~tap_ready.
REQ-025 Latency: a header appears on tap_valid 2 cycles after rvalid rises in IDLE with an empty FIFO; a data word appears 1 cycle after its handshake.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width $clog2(FIFO_DEPTH)+1.

Reset
REQ-027 On resetn=0: FSM IDLE, FIFO empty, beat_idx=0, err_resp=err_overflow=0, tap_valid=0, tap_last=0, tap_data=0, in_progress=0, AXIM_rready=0, AXIS_rvalid=0.
REQ-028 Reset mid-burst SHALL discard FIFO contents and the open burst; no partial frame is emitted after release.

Structure
REQ-029 Package axi_r_stream_tap_pkg SHALL hold the FSM state enum and the AXI resp constants OKAY/EXOKAY/SLVERR/DECERR.
REQ-030 The FIFO SHALL be a sub-module stream_fifo (parameters WIDTH=DATA_WIDTH+1 and DEPTH).

Verification
REQ-031 4-beat burst, id=0x5, rresp=0, tap_ready=1 -> tap words: header {010,0..,0x5}, then 4 data words, last on the 4th; in_progress high through the burst.
REQ-032 Beat 2 of 3 with rresp=2'b10 -> word 2 = {010,0..,idx=1,2'b10}; err_resp=1 and stays 1.
REQ-033 FIFO_DEPTH=4, tap_ready=0, 8-beat burst -> AXIM_rready drops after header + 3 beats; resuming tap_ready completes all 9 words in order with none lost.
REQ-034 MAX_BURST=4, 6-beat burst without rlast on beat 4 -> err_overflow=1; 4th word last=1; FSM IDLE.
REQ-035 resetn pulsed low mid-burst, 2 words buffered -> tap_valid=0 immediately; next burst emits a fresh header.
